// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

    // Qualification FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module bit_synchronizer
    import debounce_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw bit through the chain; the oldest stage is the output
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises a raw level, accepts a new level only after
// STABLE_CYCLES consecutive equal samples, and emits one-cycle rise/fall pulses.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt
// output counting aborted qualifications.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W      = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    output logic                out,
    output logic                rise,
    output logic                fall,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (s)
    );

    // Qualification FSM with counter, debounced level and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= '0;
`endif
        end else begin
            // Pulses last one cycle unless re-armed below
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s != out) begin
                        state <= ST_COUNT;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (s == out) begin
                        // Candidate level fell back before qualifying
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (glitch_cnt != '1) begin
                            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
                        end
`endif
                    end else if (cnt == CNT_LAST) begin
                        out   <= s;
                        rise  <= s;
                        fall  <= ~s;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_switch_debouncer;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int MAXG   = 255;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int GW     = 8;
    logic [GW-1:0] glitch_cnt;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic out, rise, fall, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit   pipe[$];
    logic m_out, m_rise, m_fall;
    int   m_run, m_glitch;

    typedef struct {
        logic rst;
        logic in;
        logic out;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    switch_debouncer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .GLITCH_W     (GW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out),
        .rise(rise),
        .fall(fall),
        .busy(busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare against it
    task automatic step(input logic rv, input logic iv);
        bit sv;
        @(negedge clk);
        rst = rv;
        in  = iv;
        @(posedge clk);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rv) begin
            m_out    = 1'b0;
            m_run    = 0;
            m_glitch = 0;
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
        end else begin
            // The level the FSM sees is the raw input from SYNC edges ago
            sv = pipe.pop_front();
            pipe.push_back(iv);
            if (sv != m_out) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_out  = sv;
                    m_rise = sv;
                    m_fall = !sv;
                    m_run  = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < MAXG) m_glitch++;
                m_run = 0;
            end
        end
        #1;
        check("model_out", int'(out), int'(m_out));
        check("model_rise", int'(rise), int'(m_rise));
        check("model_fall", int'(fall), int'(m_fall));
        check("model_busy", int'(busy), (m_run > 0) ? 1 : 0);
        check("rise_fall_excl", int'(rise & fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("model_glitch", int'(glitch_cnt), m_glitch);
`endif
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        int idx, nrise, nout, hold;
        logic r;
        rst = 1'b1;
        in  = 1'b0;

        // Reset with in=1, release, clean rise, then clean fall
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].in);
            check($sformatf("tbl%0d_out", i), int'(out), int'(tbl[i].out));
            check($sformatf("tbl%0d_rise", i), int'(rise), int'(tbl[i].rise));
            check($sformatf("tbl%0d_fall", i), int'(fall), int'(tbl[i].fall));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check($sformatf("tbl%0d_glitch", i), int'(glitch_cnt), 0);
`endif
        end

        // Short glitch is rejected
        do_reset();
        nrise = 0;
        nout  = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i < 2) ? 1'b1 : 1'b0);
            nrise += int'(rise);
            nout  += int'(out);
        end
        check("glitch_no_rise", nrise, 0);
        check("glitch_out_low", nout, 0);
        check("glitch_busy_low", int'(busy), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_one", int'(glitch_cnt), 1);
`endif

        // Bounce train of five short pulses, then a held high level
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 1 + (p % 2); i++) step(1'b0, 1'b1);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        end
        check("bounce_out_low", int'(out), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitch5", int'(glitch_cnt), 5);
`endif
        idx   = -1;
        nrise = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1);
            nrise += int'(rise);
            if (out && idx < 0) idx = i;
        end
        check("bounce_latency", idx, 5);
        check("bounce_one_rise", nrise, 1);

        // Reset in the middle of qualification discards the change
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("midrst_busy_before", int'(busy), 1);
        step(1'b1, 1'b1);
        check("midrst_out", int'(out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rise", int'(rise), 0);
        idx   = -1;
        nrise = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1);
            nrise += int'(rise);
            if (rise && idx < 0) idx = i;
        end
        check("midrst_rise_lat", idx, 5);
        check("midrst_one_rise", nrise, 1);

        // Random levels with random hold times and occasional resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r    = ($urandom_range(0, 99) == 0);
            hold = $urandom_range(1, 8);
            in   = 1'($urandom_range(0, 1));
            for (int i = 0; i < hold; i++) step(r && i == 0, in);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
